// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
// Imported by the fetch unit and its prefetch FIFO.
package cpu_pkg;

  localparam int XLEN        = 64;
  localparam int ILEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] pc
  );
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Prefetch FIFO of {pc, instr} entries with flush.
// Head output holds the last valid head while empty.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  fetch_entry_t last_q, last_d;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign head = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    last_d   = head;
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: PC, single in-flight
// request tracking, redirect/drop, and prefetch FIFO.
module fetch_prefetch_unit
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            outstanding_q, outstanding_d;
  logic            drop_q, drop_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty, fifo_full;
  logic            req_fire, rsp_fire;
  logic            push, pop;
  fetch_entry_t    push_data, head;

  assign imem_req_valid = !rst && !outstanding_q &&
                          !redirect_valid &&
                          (fifo_count < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid && outstanding_q;

  assign push = rsp_fire && !drop_q &&
                !redirect_valid && !fifo_full;
  assign pop  = instr_valid && instr_ready;

  assign push_data = '{pc: req_pc_q, instr: imem_rsp_data};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (req_fire) begin
      fetch_pc_d    = fetch_pc_q + STEP;
      req_pc_d      = fetch_pc_q;
      outstanding_d = 1'b1;
    end
    if (rsp_fire) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
    end
    // A stale response still in flight must be eaten later.
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
      if (outstanding_q && !imem_rsp_valid) begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: memory responder plus
// a stream-level model of expected fetch order.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(
    .DEPTH(4),
    .RESET_PC(64'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  bit          mem_pending = 0;
  logic [63:0] mem_addr = '0;
  int          mem_wait = 0;
  int          mem_lat = 1;
  int          ready_mode = 0;
  int          stall_left = 0;
  bit          rand_ready = 0;

  logic [63:0] req_q[$];
  int          req_cyc_q[$];
  logic [63:0] pop_pc_q[$];
  logic [31:0] pop_data_q[$];
  int          pop_cyc_q[$];

  logic        s_valid, s_ready;
  logic [63:0] s_addr;

  function automatic logic [31:0] mem_word(
    input logic [63:0] a
  );
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
  endfunction

  task automatic cycle_begin();
    if (mem_pending && mem_wait == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_addr);
      mem_pending    = 0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (mem_pending) mem_wait--;
    end
    case (ready_mode)
      0: imem_req_ready = 1'b1;
      1: begin
        if (stall_left > 0) begin
          imem_req_ready = 1'b0;
          stall_left--;
        end else if ($urandom_range(0, 1) == 1) begin
          imem_req_ready = 1'b0;
          stall_left = $urandom_range(0, 2);
        end else begin
          imem_req_ready = 1'b1;
        end
      end
      default: imem_req_ready = 1'b0;
    endcase
    if (rand_ready) instr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic cycle_end();
    @(negedge clk);
    s_valid = imem_req_valid;
    s_ready = imem_req_ready;
    s_addr  = imem_req_addr;
    if (imem_req_valid && imem_req_ready) begin
      req_q.push_back(imem_req_addr);
      req_cyc_q.push_back(cyc);
      mem_pending = 1;
      mem_addr    = imem_req_addr;
      mem_wait    = mem_lat - 1;
    end
    if (instr_valid && instr_ready &&
        !redirect_valid && !rst) begin
      pop_pc_q.push_back(instr_pc);
      pop_data_q.push_back(instr);
      pop_cyc_q.push_back(cyc);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    cycle_begin();
    cycle_end();
  endtask

  task automatic clear_logs();
    req_q.delete();
    req_cyc_q.delete();
    pop_pc_q.delete();
    pop_data_q.delete();
    pop_cyc_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    mem_pending = 0;
    ready_mode = 0;
    rand_ready = 0;
    mem_lat = 1;
    stall_left = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    clear_logs();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0)
      $display("FAIL rst_req_valid: got %b want 0", imem_req_valid);
    else n_pass++;
    n_checks++;
    if (instr_valid !== 1'b0)
      $display("FAIL rst_instr_valid: got %b want 0", instr_valid);
    else n_pass++;
    n_checks++;
    if (instr !== 32'h0 || instr_pc !== 64'h0)
      $display("FAIL rst_outputs: got %h/%h want 0/0", instr, instr_pc);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (imem_req_valid !== 1'b0)
      $display("FAIL rst_held_req: got %b want 0", imem_req_valid);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0)
      $display("FAIL rst_release: got %b/%h want 1/0",
               imem_req_valid, imem_req_addr);
    else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    instr_ready = 1'b1;
    repeat (14) tick();
    n_checks++;
    if (pop_pc_q.size() < 4 || req_q.size() < 1) begin
      $display("FAIL stream_count: got %0d want >=4", pop_pc_q.size());
    end else begin
      n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (pop_pc_q[i] !== 64'(4 * i) ||
            pop_data_q[i] !== mem_word(64'(4 * i)))
          $display("FAIL stream_entry%0d: got %h/%h want %h/%h", i,
                   pop_pc_q[i], pop_data_q[i], 4 * i, mem_word(64'(4 * i)));
        else n_pass++;
      end
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (pop_cyc_q[i] - pop_cyc_q[i-1] != 2)
          $display("FAIL stream_spacing%0d: got %0d want 2", i,
                   pop_cyc_q[i] - pop_cyc_q[i-1]);
        else n_pass++;
      end
      n_checks++;
      if (pop_cyc_q[0] - req_cyc_q[0] != 2)
        $display("FAIL stream_latency: got %0d want 2",
                 pop_cyc_q[0] - req_cyc_q[0]);
      else n_pass++;
    end
  endtask

  task automatic test_fill();
    do_reset();
    instr_ready = 1'b0;
    repeat (20) tick();
    n_checks++;
    if (req_q.size() != 4)
      $display("FAIL fill_reqs: got %0d want 4", req_q.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < req_q.size(); i++) begin
      n_checks++;
      if (req_q[i] !== 64'(4 * i))
        $display("FAIL fill_addr%0d: got %h want %h", i, req_q[i], 4 * i);
      else n_pass++;
    end
    n_checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1)
      $display("FAIL fill_full: got %b/%b want 0/1",
               imem_req_valid, instr_valid);
    else n_pass++;
    instr_ready = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (pop_pc_q.size() < 4)
      $display("FAIL drain_count: got %0d want >=4", pop_pc_q.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < pop_pc_q.size(); i++) begin
      n_checks++;
      if (pop_pc_q[i] !== 64'(4 * i) ||
          pop_data_q[i] !== mem_word(64'(4 * i)))
        $display("FAIL drain_entry%0d: got %h/%h want %h", i,
                 pop_pc_q[i], pop_data_q[i], 4 * i);
      else n_pass++;
    end
    n_checks++;
    if (req_q.size() < 5 || req_q[4] !== 64'h10)
      $display("FAIL fill_resume: got %0d reqs want 5th at 10",
               req_q.size());
    else n_pass++;
  endtask

  task automatic test_redirect_inflight();
    bit found = 0;
    int n_pre;
    do_reset();
    mem_lat = 2;
    instr_ready = 1'b1;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (req_q.size() > 0 && req_q[req_q.size()-1] == 64'h8)
        found = 1;
    end
    n_checks++;
    if (!found) $display("FAIL rdi_setup: got no req 8 want req 8");
    else n_pass++;
    cycle_begin();
    redirect_valid = 1'b1;
    redirect_pc = 64'h1000;
    cycle_end();
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0)
      $display("FAIL rdi_flush: got %b want 0", instr_valid);
    else n_pass++;
    n_pre = pop_pc_q.size();
    tick();
    n_checks++;
    if (instr_valid !== 1'b0)
      $display("FAIL rdi_drop: got %b want 0", instr_valid);
    else n_pass++;
    repeat (12) tick();
    foreach (pop_pc_q[i]) begin
      if (pop_pc_q[i] == 64'h8) begin
        n_checks++;
        $display("FAIL rdi_stale: got pc 8 presented want never");
      end
    end
    n_checks++;
    if (pop_pc_q.size() <= n_pre)
      $display("FAIL rdi_next: got no pop want pc 1000");
    else if (pop_pc_q[n_pre] !== 64'h1000 ||
             pop_data_q[n_pre] !== mem_word(64'h1000))
      $display("FAIL rdi_next: got %h/%h want 1000/%h",
               pop_pc_q[n_pre], pop_data_q[n_pre], mem_word(64'h1000));
    else n_pass++;
  endtask

  task automatic test_redirect_coincident();
    bit found = 0;
    int n_pre;
    logic [63:0] rsp_pc = '0;
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 50 && !found; i++) begin
      cycle_begin();
      if (imem_rsp_valid && req_q.size() >= 3) begin
        rsp_pc = mem_addr;
        redirect_valid = 1'b1;
        redirect_pc = 64'h2002;
        found = 1;
      end
      cycle_end();
    end
    redirect_valid = 1'b0;
    #1;
    n_checks++;
    if (!found || imem_req_valid !== 1'b1 ||
        imem_req_addr !== 64'h2000)
      $display("FAIL rdc_req: got %b/%h want 1/2000",
               imem_req_valid, imem_req_addr);
    else n_pass++;
    n_checks++;
    if (instr_valid !== 1'b0)
      $display("FAIL rdc_flush: got %b want 0", instr_valid);
    else n_pass++;
    n_pre = pop_pc_q.size();
    repeat (10) tick();
    n_checks++;
    if (pop_pc_q.size() <= n_pre)
      $display("FAIL rdc_next: got no pop want pc 2000");
    else if (pop_pc_q[n_pre] !== 64'h2000 ||
             pop_data_q[n_pre] !== mem_word(64'h2000))
      $display("FAIL rdc_next: got %h/%h want 2000/%h",
               pop_pc_q[n_pre], pop_data_q[n_pre], mem_word(64'h2000));
    else n_pass++;
    foreach (pop_pc_q[i]) begin
      if (pop_pc_q[i] == rsp_pc) begin
        n_checks++;
        $display("FAIL rdc_stale: got pc %h presented want never", rsp_pc);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    do_reset();
    mem_lat = 3;
    instr_ready = 1'b0;
    while (req_q.size() < 4 && guard < 60) begin
      tick();
      guard++;
    end
    n_checks++;
    if (req_q.size() != 4 || instr_valid !== 1'b1)
      $display("FAIL rm_setup: got %0d reqs/%b want 4/1",
               req_q.size(), instr_valid);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 ||
        instr !== 32'h0 || instr_pc !== 64'h0)
      $display("FAIL rm_zero: got %b %b %h %h want 0 0 0 0",
               imem_req_valid, instr_valid, instr, instr_pc);
    else n_pass++;
    clear_logs();
    ready_mode = 2;
    tick();
    rst = 1'b0;
    guard = 0;
    while (mem_pending && guard < 10) begin
      tick();
      guard++;
    end
    n_checks++;
    if (mem_pending || instr_valid !== 1'b0)
      $display("FAIL rm_orphan: got %b want instr_valid 0", instr_valid);
    else n_pass++;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0)
      $display("FAIL rm_restart: got %b/%h want 1/0",
               imem_req_valid, imem_req_addr);
    else n_pass++;
    ready_mode = 0;
    mem_lat = 1;
    instr_ready = 1'b1;
    repeat (12) tick();
    n_checks++;
    if (pop_pc_q.size() < 2 || pop_pc_q[0] !== 64'h0 ||
        pop_data_q[0] !== mem_word(64'h0) || pop_pc_q[1] !== 64'h4)
      $display("FAIL rm_first: got %0d pops want pc 0,4 with mem data",
               pop_pc_q.size());
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [63:0] base = 64'hFFFF_FFFF_FFFF_FFF0;
    logic [63:0] exp_pc;
    logic        pv = 1'b0, pr = 1'b0;
    logic [63:0] pa = '0;
    bit          wrapped = 0;
    do_reset();
    cycle_begin();
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFF1;
    cycle_end();
    redirect_valid = 1'b0;
    clear_logs();
    ready_mode = 1;
    rand_ready = 1;
    for (int i = 0; i < 150; i++) begin
      mem_lat = $urandom_range(1, 2);
      tick();
      if (pv && !pr) begin
        n_checks++;
        if (s_valid !== 1'b1 || s_addr !== pa)
          $display("FAIL wrap_stall: got %b/%h want 1/%h",
                   s_valid, s_addr, pa);
        else n_pass++;
      end
      pv = s_valid;
      pr = s_ready;
      pa = s_addr;
    end
    n_checks++;
    if (pop_pc_q.size() < 8)
      $display("FAIL wrap_count: got %0d want >=8", pop_pc_q.size());
    else n_pass++;
    exp_pc = base;
    foreach (req_q[i]) begin
      n_checks++;
      if (req_q[i] !== exp_pc)
        $display("FAIL wrap_req%0d: got %h want %h", i, req_q[i], exp_pc);
      else n_pass++;
      exp_pc = exp_pc + 64'd4;
    end
    exp_pc = base;
    foreach (pop_pc_q[i]) begin
      if (pop_pc_q[i] == 64'h0) wrapped = 1;
      n_checks++;
      if (pop_pc_q[i] !== exp_pc || pop_data_q[i] !== mem_word(exp_pc))
        $display("FAIL wrap_pop%0d: got %h/%h want %h/%h", i,
                 pop_pc_q[i], pop_data_q[i], exp_pc, mem_word(exp_pc));
      else n_pass++;
      exp_pc = exp_pc + 64'd4;
    end
    n_checks++;
    if (!wrapped)
      $display("FAIL wrap_zero: got no pc 0 want wrap to 0");
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_redirect_inflight();
    test_redirect_coincident();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
